// File: rtl/maindec_pkg.sv
// Shared definitions for the main control decoder: opcodes, ALU codes,
// select-field encodings and the packed 14-bit control word.
package maindec_pkg;

  localparam int OP_W   = 4;
  localparam int CTRL_W = 14;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 4'b0000,
    OP_SUB     = 4'b0001,
    OP_ADD_ALT = 4'b0010,
    OP_JR      = 4'b0011,
    OP_AND     = 4'b0100,
    OP_OR      = 4'b0101,
    OP_SLL     = 4'b0110,
    OP_SRL     = 4'b0111,
    OP_SLT     = 4'b1000,
    OP_BEQ     = 4'b1001,
    OP_ADDI    = 4'b1010,
    OP_SUBI    = 4'b1011,
    OP_LW      = 4'b1100,
    OP_SW      = 4'b1101,
    OP_J       = 4'b1110,
    OP_JAL     = 4'b1111
  } opcode_e;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Write-register select
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  // Writeback select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // PC select
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_SHAMT = 2'b10;

  // Control word, MSB first in port order
  typedef struct packed {
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       branch;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic [1:0] alu_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // Builds a control word from its fields in port order
  function automatic ctrl_t mk_ctrl(
    input logic       reg_write,
    input logic [1:0] reg_dst,
    input logic       branch,
    input logic       mem_write,
    input logic [1:0] mem_to_reg,
    input logic [1:0] jump,
    input logic [1:0] alu_src,
    input logic [2:0] alu_ctrl
  );
    ctrl_t c;
    c.reg_write  = reg_write;
    c.reg_dst    = reg_dst;
    c.branch     = branch;
    c.mem_write  = mem_write;
    c.mem_to_reg = mem_to_reg;
    c.jump       = jump;
    c.alu_src    = alu_src;
    c.alu_ctrl   = alu_ctrl;
    return c;
  endfunction

endpackage

// File: rtl/maindec.sv
// Main control decoder. Combinational control outputs follow op with zero
// latency; a registered copy of the control word and opcode is kept for
// pipelined or trace consumers.
module maindec
  import maindec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  output logic              regWrite,
  output logic [1:0]        regDst,
  output logic              branch,
  output logic              memWrite,
  output logic [1:0]        memToReg,
  output logic [1:0]        jump,
  output logic [1:0]        aluSrc,
  output logic [2:0]        aluCtrl,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [OP_W-1:0]   op_q
);

  ctrl_t             w_ctrl;
  ctrl_t             r_ctrl_q;
  logic [OP_W-1:0]   r_op_q;

  // Opcode decode; an opcode with X/Z bits matches no item and falls to the
  // all-zero default, which is a harmless NOP
  always_comb begin
    w_ctrl = '0;
    case (op)
      OP_ADD:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_ADD);
      OP_SUB:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_SUB);
      OP_ADD_ALT: w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_ADD);
      OP_JR:      w_ctrl = mk_ctrl(1'b0, DST_RT,   1'b0, 1'b0, WB_ALU,  PC_REG,  SRC_REG,   ALU_ADD);
      OP_AND:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_AND);
      OP_OR:      w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_OR);
      OP_SLL:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_SHAMT, ALU_SLL);
      OP_SRL:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_SHAMT, ALU_SRL);
      OP_SLT:     w_ctrl = mk_ctrl(1'b1, DST_RD,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_SLT);
      OP_BEQ:     w_ctrl = mk_ctrl(1'b0, DST_RT,   1'b1, 1'b0, WB_ALU,  PC_SEQ,  SRC_REG,   ALU_SUB);
      OP_ADDI:    w_ctrl = mk_ctrl(1'b1, DST_RT,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_IMM,   ALU_ADD);
      OP_SUBI:    w_ctrl = mk_ctrl(1'b1, DST_RT,   1'b0, 1'b0, WB_ALU,  PC_SEQ,  SRC_IMM,   ALU_SUB);
      OP_LW:      w_ctrl = mk_ctrl(1'b1, DST_RT,   1'b0, 1'b0, WB_MEM,  PC_SEQ,  SRC_IMM,   ALU_ADD);
      OP_SW:      w_ctrl = mk_ctrl(1'b0, DST_RT,   1'b0, 1'b1, WB_ALU,  PC_SEQ,  SRC_IMM,   ALU_ADD);
      OP_J:       w_ctrl = mk_ctrl(1'b0, DST_RT,   1'b0, 1'b0, WB_ALU,  PC_JUMP, SRC_REG,   ALU_ADD);
      OP_JAL:     w_ctrl = mk_ctrl(1'b1, DST_LINK, 1'b0, 1'b0, WB_LINK, PC_JUMP, SRC_REG,   ALU_ADD);
      default:    w_ctrl = '0;
    endcase
  end

  // Registered copy of control word and opcode, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctrl_q <= '0;
      r_op_q   <= '0;
    end else begin
      r_ctrl_q <= w_ctrl;
      r_op_q   <= op;
    end
  end

  assign regWrite = w_ctrl.reg_write;
  assign regDst   = w_ctrl.reg_dst;
  assign branch   = w_ctrl.branch;
  assign memWrite = w_ctrl.mem_write;
  assign memToReg = w_ctrl.mem_to_reg;
  assign jump     = w_ctrl.jump;
  assign aluSrc   = w_ctrl.alu_src;
  assign aluCtrl  = w_ctrl.alu_ctrl;
  assign ctrl_q   = r_ctrl_q;
  assign op_q     = r_op_q;

endmodule

// File: tb/tb_maindec.sv
// Directed self-checking bench for maindec: combinational decode sweep,
// registered path latency, and synchronous reset behaviour.
module tb_maindec;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        regWrite;
  logic [1:0]  regDst;
  logic        branch;
  logic        memWrite;
  logic [1:0]  memToReg;
  logic [1:0]  jump;
  logic [1:0]  aluSrc;
  logic [2:0]  aluCtrl;
  logic [13:0] ctrl_q;
  logic [3:0]  op_q;

  int n_checks;
  int n_fail;

  logic [13:0] exp_tbl [16];
  logic [13:0] exp_q [$];

  maindec dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .regWrite (regWrite),
    .regDst   (regDst),
    .branch   (branch),
    .memWrite (memWrite),
    .memToReg (memToReg),
    .jump     (jump),
    .aluSrc   (aluSrc),
    .aluCtrl  (aluCtrl),
    .ctrl_q   (ctrl_q),
    .op_q     (op_q)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_fail = n_fail + 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] comb_word();
    return {regWrite, regDst, branch, memWrite, memToReg, jump, aluSrc, aluCtrl};
  endfunction

  // driver tasks
  task automatic drive_op(input logic [3:0] v);
    @(negedge clk);
    op = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic probe;
    logic [13:0] e;
    n_checks = 0;
    n_fail   = 0;
    // hand-computed table: regWrite regDst branch memWrite memToReg jump aluSrc aluCtrl
    exp_tbl[0]  = 14'b1_01_0_0_00_00_00_010;
    exp_tbl[1]  = 14'b1_01_0_0_00_00_00_110;
    exp_tbl[2]  = 14'b1_01_0_0_00_00_00_010;
    exp_tbl[3]  = 14'b0_00_0_0_00_10_00_010;
    exp_tbl[4]  = 14'b1_01_0_0_00_00_00_000;
    exp_tbl[5]  = 14'b1_01_0_0_00_00_00_001;
    exp_tbl[6]  = 14'b1_01_0_0_00_00_10_011;
    exp_tbl[7]  = 14'b1_01_0_0_00_00_10_101;
    exp_tbl[8]  = 14'b1_01_0_0_00_00_00_111;
    exp_tbl[9]  = 14'b0_00_1_0_00_00_00_110;
    exp_tbl[10] = 14'b1_00_0_0_00_00_01_010;
    exp_tbl[11] = 14'b1_00_0_0_00_00_01_110;
    exp_tbl[12] = 14'b1_00_0_0_01_00_01_010;
    exp_tbl[13] = 14'b0_00_0_1_00_00_01_010;
    exp_tbl[14] = 14'b0_00_0_0_00_01_00_010;
    exp_tbl[15] = 14'b1_10_0_0_10_01_00_010;

    reset = 1'b0;
    op    = 4'b0000;

    // combinational sweep of all opcodes
    for (int i = 0; i < 16; i++) begin
      drive_op(4'(i));
      #1;
      check($sformatf("comb_op%0d", i), 32'(comb_word()), 32'(exp_tbl[i]));
    end

    // field-level check for lw
    drive_op(4'b1100);
    #1;
    check("lw_regWrite", 32'(regWrite), 32'd1);
    check("lw_memToReg", 32'(memToReg), 32'd1);
    check("lw_aluSrc",   32'(aluSrc),   32'd1);
    check("lw_aluCtrl",  32'(aluCtrl),  32'd2);

    // reset held 3 cycles with jal
    drive_op(4'b1111);
    reset = 1'b0;
    step(); step(); step();
    check("rst_ctrl_q", 32'(ctrl_q), 32'd0);
    check("rst_op_q",   32'(op_q),   32'd0);
    check("rst_regWrite", 32'(regWrite), 32'd1);
    check("rst_regDst",   32'(regDst),   32'd2);
    check("rst_memToReg", 32'(memToReg), 32'd2);
    check("rst_jump",     32'(jump),     32'd1);

    // release, beq
    drive_op(4'b1001);
    reset = 1'b1;
    step();
    check("beq_ctrl_q", 32'(ctrl_q), 32'(14'b0_00_1_0_00_00_00_110));
    check("beq_op_q",   32'(op_q),   32'd9);

    // back-to-back sll / srl with 1-cycle lag
    drive_op(4'b0110);
    #1;
    check("sll_lag_ctrl_q", 32'(ctrl_q), 32'(exp_tbl[9]));
    step();
    check("sll_ctrl_q", 32'(ctrl_q), 32'(14'b1_01_0_0_00_00_10_011));
    op = 4'b0111;
    #1;
    check("srl_lag_ctrl_q", 32'(ctrl_q), 32'(exp_tbl[6]));
    step();
    check("srl_ctrl_q", 32'(ctrl_q), 32'(14'b1_01_0_0_00_00_10_101));
    check("srl_op_q",   32'(op_q),   32'd7);

    // mid-stream reset with sw
    drive_op(4'b1101);
    reset = 1'b0;
    #1;
    check("pre_rst_ctrl_q", 32'(ctrl_q), 32'(exp_tbl[7]));
    step();
    check("mid_rst_ctrl_q", 32'(ctrl_q), 32'd0);
    check("mid_rst_op_q",   32'(op_q),   32'd0);
    check("mid_rst_memWrite", 32'(memWrite), 32'd1);
    check("mid_rst_regWrite", 32'(regWrite), 32'd0);

    // registered sweep with scoreboard queue
    reset = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      drive_op(4'(i));
      exp_q.push_back(exp_tbl[i]);
      step();
      e = exp_q.pop_front();
      check($sformatf("reg_op%0d", i), 32'(ctrl_q), 32'(e));
      check($sformatf("reg_opq%0d", i), 32'(op_q), 32'(i));
    end

    // unknown opcode gives all-zero outputs where the simulator is 4-state
    probe = 1'bx;
    drive_op(4'bxxxx);
    #1;
    if ($isunknown(probe)) begin
      check("x_op_comb", 32'(comb_word()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maindec.md
Name: maindec

Overview:
- Main control decoder for the team's 16-bit, 4-bit-opcode single-cycle CPU.
- Maps the instruction opcode to datapath control signals: register write, destination select, branch, memory write, writeback select, jump select, ALU source and ALU operation.
- Primary outputs are purely combinational, with zero latency, and feed the datapath directly.
- A registered copy of the control word is also provided for pipelined or trace consumers.

Parameters:
- None. The opcode width (4) and control-word width (14) are fixed constants in the shared package.

Ports:
- clk       input   1  clock, rising edge
- reset     input   1  synchronous, active-low reset
- op        input   4  instruction opcode
- regWrite  output  1  register file write enable
- regDst    output  2  write-register select: 00 rt/imm-form, 01 rd (R-type), 10 link register (jal)
- branch    output  1  conditional branch
- memWrite  output  1  data memory write enable
- memToReg  output  2  writeback select: 00 ALU, 01 memory, 10 PC+1 (link)
- jump      output  2  PC select: 00 sequential/branch, 01 jump target, 10 register (jr)
- aluSrc    output  2  ALU B select: 00 register, 01 immediate, 10 shift amount
- aluCtrl   output  3  ALU operation code
- ctrl_q    output 14  registered control word {regWrite, regDst, branch, memWrite, memToReg, jump, aluSrc, aluCtrl}, MSB first
- op_q      output  4  registered opcode aligned with ctrl_q

Behaviour:
- Combinational outputs depend only on op. They are not affected by clk or reset.
- Decode table, listed as op: regWrite regDst branch memWrite memToReg jump aluSrc aluCtrl:
  - 0000 add: 1 01 0 0 00 00 00 010
  - 0001 sub: 1 01 0 0 00 00 00 110
  - 0010: 1 01 0 0 00 00 00 010
  - 0011 jr: 0 00 0 0 00 10 00 010
  - 0100 and: 1 01 0 0 00 00 00 000
  - 0101 or: 1 01 0 0 00 00 00 001
  - 0110 sll: 1 01 0 0 00 00 10 011
  - 0111 srl: 1 01 0 0 00 00 10 101
  - 1000 slt: 1 01 0 0 00 00 00 111
  - 1001 beq: 0 00 1 0 00 00 00 110
  - 1010 addi: 1 00 0 0 00 00 01 010
  - 1011 subi: 1 00 0 0 00 00 01 110
  - 1100 lw: 1 00 0 0 01 00 01 010
  - 1101 sw: 0 00 0 1 00 00 01 010
  - 1110 j: 0 00 0 0 00 01 00 010
  - 1111 jal: 1 10 0 0 10 01 00 010
- All 16 opcodes are legal.
- If op contains X/Z, all combinational outputs are driven to 0 (safe NOP: no write, no branch, no jump).
- Registered path, on each rising clk edge:
  - reset=0: ctrl_q <= 0 and op_q <= 0.
  - Otherwise: ctrl_q <= current combinational control word, and op_q <= op. Latency is 1 cycle.
- Reset is sampled only at clk edges. Asserting it mid-stream clears ctrl_q/op_q at the next edge; combinational outputs keep tracking op.
- No internal state other than ctrl_q and op_q.

Decomposition:
- Shared package maindec_pkg contains:
  - opcode enum (4-bit, 16 values above);
  - ALU control constants: AND 000, OR 001, ADD 010, SLL 011, SRL 101, SUB 110, SLT 111;
  - 2-bit select constants for regDst, memToReg, jump and aluSrc;
  - packed struct ctrl_t for the 14-bit word in the port order above.
- Single module with one combinational case block and one always_ff register. No sub-module.

Test Plan:
- Sweep op 0000..1111 and check each combinational output against the table, e.g. op=1100 -> regWrite=1, memToReg=01, aluSrc=01, aluCtrl=010.
- Hold reset=0 for 3 cycles with op=1111 -> ctrl_q=0 and op_q=0. Combinational outputs still show regWrite=1, regDst=10, memToReg=10, jump=01.
- Release reset, apply op=1001 -> after the next rising edge ctrl_q = 14'b0_00_1_0_00_00_00_110 and op_q=1001.
- Back-to-back op=0110 then 0111 -> ctrl_q follows with 1-cycle lag; aluSrc=10 in both, aluCtrl 011 then 101.
- Assert reset while op=1101 -> ctrl_q clears at that edge. Combinational memWrite stays 1 and regWrite stays 0.
- Drive op=4'bxxxx -> all combinational outputs 0.
